// File: rtl/adc_sample_averager_pkg.sv
// adc_sample_averager_pkg: shared constants and FSM state encoding for the ADC averager
//   ADC_W_DEF   default raw sample width
//   ACC_GROWTH  extra accumulator bits, log2 of the largest window (64)
//   CNT_W       width of the discard/sample counter
//   avg_state_t averager FSM states
package adc_sample_averager_pkg;
    localparam int ADC_W_DEF  = 12;
    localparam int ACC_GROWTH = 6;
    localparam int ACC_W_DEF  = ADC_W_DEF + ACC_GROWTH;
    localparam int CNT_W      = 8;
    typedef enum logic [1:0] {IDLE, DISCARD, ACCUM, PUBLISH} avg_state_t;
endpackage

// File: rtl/adc_avg_round.sv
// adc_avg_round: combinational round-half-up and divide by 4^sel
//   sum  accumulated window total
//   sel  window select, divisor is 2^(2*sel)
//   avg  rounded average
module adc_avg_round #(
    parameter int ADC_W = 12,
    parameter int ACC_W = 18
) (
    input  logic [ACC_W-1:0] sum,
    input  logic [1:0]       sel,
    output logic [ADC_W-1:0] avg
);
    logic [ACC_W-1:0] half;
    logic [ACC_W-1:0] rounded;
    always_comb begin
        // half = 2^(k-1), which collapses to 0 when k = 0
        half    = (ACC_W'(1) << {sel, 1'b0}) >> 1;
        rounded = sum + half;
        avg     = ADC_W'(rounded >> {sel, 1'b0});
    end
endmodule

// File: rtl/adc_sample_averager.sv
// adc_sample_averager: requests ADC conversions, drops settling samples, averages 4^AVG_SEL codes
//   SAMPLE_CLK        clock, rising edge
//   NRST_sync         asynchronous active-low reset
//   ENMONTSENSE_sync  conversion enable; rising edge starts, low aborts
//   AVG_SEL           window size select, N = 4^AVG_SEL
//   ADC_REQ           one-cycle conversion request
//   ADC_VALID/DATA    conversion result strobe and code
//   RESULT            rounded average, held between DONE pulses
//   DONE              one-cycle pulse with each new RESULT
//   BUSY              FSM not idle
module adc_sample_averager
    import adc_sample_averager_pkg::*;
#(
    parameter int ADC_W     = ADC_W_DEF,
    parameter int DISCARD_N = 2
) (
    input  logic             SAMPLE_CLK,
    input  logic             NRST_sync,
    input  logic             ENMONTSENSE_sync,
    input  logic [1:0]       AVG_SEL,
    output logic             ADC_REQ,
    input  logic             ADC_VALID,
    input  logic [ADC_W-1:0] ADC_DATA,
    output logic [15:0]      RESULT,
    output logic             DONE,
    output logic             BUSY
);
    localparam int ACC_W = ADC_W + ACC_GROWTH;

    avg_state_t       state;
    logic             en_low_q;
    logic             pending;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [ADC_W-1:0] avg;
    logic [CNT_W-1:0] win_last;
    logic             rise;
    logic             accept;

    // en_low_q means "enable was seen low last cycle"; clearing it on reset keeps
    // an enable that is already high from counting as a rising edge
    assign rise     = ENMONTSENSE_sync & en_low_q;
    assign accept   = ADC_VALID & pending & (state == DISCARD || state == ACCUM);
    assign win_last = (CNT_W'(1) << {sel_q, 1'b0}) - CNT_W'(1);
    assign BUSY     = state != IDLE;

    adc_avg_round #(.ADC_W(ADC_W), .ACC_W(ACC_W)) u_round (
        .sum(acc),
        .sel(sel_q),
        .avg(avg)
    );

    always_ff @(posedge SAMPLE_CLK or negedge NRST_sync) begin
        if (!NRST_sync) begin
            state    <= IDLE;
            en_low_q <= 1'b0;
            pending  <= 1'b0;
            sel_q    <= '0;
            cnt      <= '0;
            acc      <= '0;
            RESULT   <= '0;
            DONE     <= 1'b0;
            ADC_REQ  <= 1'b0;
        end else begin
            en_low_q <= !ENMONTSENSE_sync;
            DONE     <= 1'b0;
            ADC_REQ  <= 1'b0;
            // a window already complete in PUBLISH is still delivered
            if ((state == DISCARD || state == ACCUM) && !ENMONTSENSE_sync) begin
                state   <= IDLE;
                pending <= 1'b0;
                cnt     <= '0;
                acc     <= '0;
            end else begin
                case (state)
                    IDLE: if (rise) begin
                        state   <= DISCARD_N == 0 ? ACCUM : DISCARD;
                        sel_q   <= AVG_SEL;
                        ADC_REQ <= 1'b1;
                        pending <= 1'b1;
                    end
                    DISCARD: if (accept) begin
                        ADC_REQ <= 1'b1;
                        if (cnt == CNT_W'(DISCARD_N - 1)) begin
                            state <= ACCUM;
                            sel_q <= AVG_SEL;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ACCUM: if (accept) begin
                        acc <= acc + ACC_W'(ADC_DATA);
                        if (cnt == win_last) begin
                            state   <= PUBLISH;
                            pending <= 1'b0;
                            cnt     <= '0;
                        end else begin
                            cnt     <= cnt + 1'b1;
                            ADC_REQ <= 1'b1;
                        end
                    end
                    PUBLISH: begin
                        RESULT <= 16'(avg);
                        DONE   <= 1'b1;
                        acc    <= '0;
                        cnt    <= '0;
                        if (ENMONTSENSE_sync) begin
                            state   <= ACCUM;
                            sel_q   <= AVG_SEL;
                            ADC_REQ <= 1'b1;
                            pending <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adc_sample_averager.sv
// tb_adc_sample_averager: directed bench for adc_sample_averager with a simple ADC responder
`timescale 1ns/1ps
module tb_adc_sample_averager;
    logic        SAMPLE_CLK = 1'b0;
    logic        NRST_sync = 1'b1;
    logic        ENMONTSENSE_sync = 1'b0;
    logic [1:0]  AVG_SEL = 2'd0;
    logic        ADC_REQ;
    logic        ADC_VALID = 1'b0;
    logic [11:0] ADC_DATA = 12'd0;
    logic [15:0] RESULT;
    logic        DONE;
    logic        BUSY;
    int          n_chk = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          d0;

    always #5 SAMPLE_CLK = ~SAMPLE_CLK;

    adc_sample_averager #(.ADC_W(12), .DISCARD_N(2)) dut (
        .SAMPLE_CLK(SAMPLE_CLK),
        .NRST_sync(NRST_sync),
        .ENMONTSENSE_sync(ENMONTSENSE_sync),
        .AVG_SEL(AVG_SEL),
        .ADC_REQ(ADC_REQ),
        .ADC_VALID(ADC_VALID),
        .ADC_DATA(ADC_DATA),
        .RESULT(RESULT),
        .DONE(DONE),
        .BUSY(BUSY)
    );

    always @(negedge SAMPLE_CLK) if (DONE) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge SAMPLE_CLK);
            #1;
        end
    endtask

    // wait (bounded) for a request, then answer two cycles later
    task automatic serve(input logic [11:0] d);
        int w = 0;
        while (!ADC_REQ && w < 20) begin
            tick();
            w++;
        end
        check("adc_req", ADC_REQ, 1);
        tick(2);
        ADC_VALID = 1'b1;
        ADC_DATA  = d;
        tick();
        ADC_VALID = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 NRST_sync = 1'b0;
        tick(2);
        check("rst_result", RESULT, 0);
        check("rst_done", DONE, 0);
        check("rst_req", ADC_REQ, 0);
        check("rst_busy", BUSY, 0);
        NRST_sync = 1'b1;
        tick(2);
        // stray valid in IDLE
        ADC_VALID = 1'b1;
        ADC_DATA  = 12'd999;
        tick();
        ADC_VALID = 1'b0;
        tick();
        check("stray_busy", BUSY, 0);
        check("stray_req", ADC_REQ, 0);
        check("stray_done", done_cnt, 0);
        check("stray_result", RESULT, 0);
        // N=4, two settling samples dropped, AVG_SEL change mid-window ignored
        AVG_SEL = 2'd1;
        ENMONTSENSE_sync = 1'b1;
        tick();
        check("start_busy", BUSY, 1);
        serve(12'd100);
        serve(12'd100);
        serve(12'd10);
        AVG_SEL = 2'd3;
        serve(12'd11);
        serve(12'd12);
        serve(12'd13);
        check("n4_publish_done", DONE, 0);
        check("n4_publish_busy", BUSY, 1);
        tick();
        check("n4_done", DONE, 1);
        check("n4_result", RESULT, 12);
        ENMONTSENSE_sync = 1'b0;
        tick();
        check("n4_abort_busy", BUSY, 0);
        check("n4_done_count", done_cnt, 1);
        // N=64 full scale, then back-to-back window without discard
        ENMONTSENSE_sync = 1'b1;
        serve(12'd0);
        serve(12'd0);
        for (int i = 0; i < 64; i++) serve(12'd4095);
        tick();
        check("n64_done", DONE, 1);
        check("n64_result", RESULT, 4095);
        check("n64_next_req", ADC_REQ, 1);
        for (int i = 0; i < 64; i++) serve(12'd2000);
        tick();
        check("n64b_done", DONE, 1);
        check("n64b_result", RESULT, 2000);
        ENMONTSENSE_sync = 1'b0;
        tick();
        // N=1 latency
        AVG_SEL = 2'd0;
        ENMONTSENSE_sync = 1'b1;
        serve(12'd5);
        serve(12'd5);
        serve(12'd777);
        check("n1_publish_done", DONE, 0);
        tick();
        check("n1_done", DONE, 1);
        check("n1_result", RESULT, 777);
        serve(12'd1234);
        tick();
        check("n1b_done", DONE, 1);
        check("n1b_result", RESULT, 1234);
        ENMONTSENSE_sync = 1'b0;
        tick();
        // abort after 7 of 16, then restart with discard
        AVG_SEL = 2'd2;
        ENMONTSENSE_sync = 1'b1;
        d0 = done_cnt;
        serve(12'd0);
        serve(12'd0);
        for (int i = 0; i < 7; i++) serve(12'd50);
        ENMONTSENSE_sync = 1'b0;
        tick();
        check("abort_busy", BUSY, 0);
        check("abort_result", RESULT, 1234);
        tick();
        check("abort_no_done", done_cnt, d0);
        ENMONTSENSE_sync = 1'b1;
        serve(12'd4000);
        serve(12'd4000);
        for (int i = 0; i < 15; i++) serve(12'd8);
        serve(12'd9);
        tick();
        check("restart_done", DONE, 1);
        check("restart_result", RESULT, 8);
        // asynchronous reset mid-ACCUM
        serve(12'd100);
        serve(12'd100);
        serve(12'd100);
        #2 NRST_sync = 1'b0;
        #1;
        check("arst_result", RESULT, 0);
        check("arst_busy", BUSY, 0);
        check("arst_req", ADC_REQ, 0);
        check("arst_done", DONE, 0);
        #2 NRST_sync = 1'b1;
        d0 = done_cnt;
        tick(5);
        check("arst_no_start_busy", BUSY, 0);
        check("arst_no_start_req", ADC_REQ, 0);
        ENMONTSENSE_sync = 1'b0;
        tick();
        ENMONTSENSE_sync = 1'b1;
        serve(12'd0);
        serve(12'd0);
        for (int i = 0; i < 16; i++) serve(12'd20);
        tick();
        check("post_rst_done", DONE, 1);
        check("post_rst_result", RESULT, 20);
        tick();
        check("post_rst_done_count", done_cnt, d0 + 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
